// File: rtl/imem_sram_seq.sv
// Sequences one packed-word request into BEATS single-port SRAM beats.
// Ports: clk0/rst0 clock and sync reset; req_* request handshake;
//        rsp_* response handshake; sram_* pins of one SRAM macro.
module imem_sram_seq #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int BEATS      = 4,
    localparam int BEAT_BITS   = $clog2(BEATS),
    localparam int WORD_WIDTH  = DATA_WIDTH * BEATS,
    localparam int PADDR_WIDTH = ADDR_WIDTH - BEAT_BITS
) (
    input  logic                   clk0,
    input  logic                   rst0,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [PADDR_WIDTH-1:0] req_addr,
    input  logic [WORD_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_we,
    output logic [WORD_WIDTH-1:0]  rsp_rdata,
    output logic                   sram_csb0,
    output logic                   sram_web0,
    output logic [ADDR_WIDTH-1:0]  sram_addr0,
    output logic [DATA_WIDTH-1:0]  sram_din0,
    input  logic [DATA_WIDTH-1:0]  sram_dout0
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [BEAT_BITS-1:0]     r_beat;
    logic [PADDR_WIDTH-1:0]   r_addr;
    logic                     r_we;
    logic [WORD_WIDTH-1:0]    r_wdata;
    logic                     r_csb;
    logic                     r_web;
    logic [ADDR_WIDTH-1:0]    r_sram_addr;
    logic [DATA_WIDTH-1:0]    r_din;
    logic                     r_rsp_valid;
    logic                     r_rsp_we;
    logic [WORD_WIDTH-1:0]    r_rdata;
    logic                     r_smp_vld;
    logic [BEAT_BITS-1:0]     r_smp_beat;

    logic                     w_accept;
    logic                     w_last;
    logic [BEAT_BITS-1:0]     w_beat_inc;
    logic                     w_csb_n;
    logic                     w_web_n;
    logic [ADDR_WIDTH-1:0]    w_addr_n;
    logic [DATA_WIDTH-1:0]    w_din_n;
    logic [BEAT_BITS-1:0]     w_beat_n;

    assign req_ready  = (r_state == IDLE) && !rst0;
    assign w_accept   = req_ready && req_valid;
    assign w_last     = (r_beat == BEAT_BITS'(BEATS - 1));
    assign w_beat_inc = r_beat + 1'b1;

    assign rsp_valid  = r_rsp_valid;
    assign rsp_we     = r_rsp_we;
    assign rsp_rdata  = r_rdata;
    assign sram_csb0  = r_csb;
    assign sram_web0  = r_web;
    assign sram_addr0 = r_sram_addr;
    assign sram_din0  = r_din;

    always_ff @(posedge clk0) begin
        if (rst0) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (w_accept)  w_state_nxt = ISSUE;
            ISSUE: if (w_last)    w_state_nxt = DRAIN;
            DRAIN:                w_state_nxt = RESP;
            RESP:  if (rsp_ready) w_state_nxt = IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered SRAM pins and beat counter.
    always_comb begin
        w_csb_n  = r_csb;
        w_web_n  = r_web;
        w_addr_n = r_sram_addr;
        w_din_n  = r_din;
        w_beat_n = r_beat;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_csb_n  = 1'b0;
                    w_web_n  = !req_we;
                    w_addr_n = {req_addr, {BEAT_BITS{1'b0}}};
                    w_din_n  = req_wdata[DATA_WIDTH-1:0];
                    w_beat_n = '0;
                end
            end
            ISSUE: begin
                if (w_last) begin
                    w_csb_n = 1'b1;
                    w_web_n = 1'b1;
                end else begin
                    w_beat_n = w_beat_inc;
                    w_addr_n = {r_addr, w_beat_inc};
                    w_din_n  = r_wdata[w_beat_inc*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_beat      <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_csb       <= 1'b1;
            r_web       <= 1'b1;
            r_sram_addr <= '0;
            r_din       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rdata     <= '0;
            r_smp_vld   <= 1'b0;
            r_smp_beat  <= '0;
        end else begin
            r_beat      <= w_beat_n;
            r_csb       <= w_csb_n;
            r_web       <= w_web_n;
            r_sram_addr <= w_addr_n;
            r_din       <= w_din_n;
            // The macro samples the current pins at this edge; its dout
            // for that beat is valid by the next edge, so remember which
            // beat was sampled and capture it one edge later.
            r_smp_vld   <= !r_csb && r_web;
            r_smp_beat  <= r_sram_addr[BEAT_BITS-1:0];
            if (r_smp_vld) begin
                r_rdata[r_smp_beat*DATA_WIDTH +: DATA_WIDTH] <= sram_dout0;
            end
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_rdata <= '0;
            end
            if (r_state == DRAIN) begin
                r_rsp_valid <= 1'b1;
                r_rsp_we    <= r_we;
            end
            if (r_state == RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_sram_seq.sv
// Randomised scoreboard bench for imem_sram_seq with an SRAM macro model.
// Ports: none; drives the DUT and a behavioural single-port SRAM.
module tb_imem_sram_seq;

    localparam int DW    = 2;
    localparam int AW    = 4;
    localparam int BEATS = 4;
    localparam int BB    = 2;
    localparam int PAW   = AW - BB;
    localparam int WW    = DW * BEATS;
    localparam int NPW   = 1 << PAW;

    logic           clk0      = 1'b0;
    logic           rst0      = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_we    = 1'b0;
    logic [PAW-1:0] req_addr  = '0;
    logic [WW-1:0]  req_wdata = '0;
    logic           rsp_ready = 1'b1;
    logic           req_ready;
    logic           rsp_valid;
    logic           rsp_we;
    logic [WW-1:0]  rsp_rdata;
    logic           sram_csb0;
    logic           sram_web0;
    logic [AW-1:0]  sram_addr0;
    logic [DW-1:0]  sram_din0;
    logic [DW-1:0]  sram_dout0;

    imem_sram_seq dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_we     (rsp_we),
        .rsp_rdata  (rsp_rdata),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    always #5 clk0 = ~clk0;

    // SRAM macro: inputs registered on posedge, dout updated on negedge.
    logic [DW-1:0] mem [1<<AW];
    logic          rd_pend = 1'b0;
    logic [AW-1:0] rd_a;

    always @(posedge clk0) begin
        rd_pend <= 1'b0;
        if (!sram_csb0) begin
            if (!sram_web0) mem[sram_addr0] <= sram_din0;
            else begin
                rd_pend <= 1'b1;
                rd_a    <= sram_addr0;
            end
        end
    end

    always @(negedge clk0) if (rd_pend) sram_dout0 <= mem[rd_a];

    // Response back-pressure.
    int stall = 0;
    int rmode = 0;
    always @(posedge clk0) begin
        #1;
        if (stall != 0)      rsp_ready = 1'b0;
        else if (rmode != 0) rsp_ready = 1'($urandom_range(0, 1));
        else                 rsp_ready = 1'b1;
    end

    // Reference model: packed-word memory; expected response per accept.
    typedef struct {
        logic          we;
        logic [WW-1:0] rd;
    } exp_t;

    logic [WW-1:0] ref_mem [NPW];
    exp_t          exp_q [$];

    always @(negedge clk0) begin
        exp_t e;
        if (!rst0 && req_valid && req_ready) begin
            e.we = req_we;
            e.rd = req_we ? '0 : ref_mem[req_addr];
            exp_q.push_back(e);
            if (req_we) ref_mem[req_addr] = req_wdata;
        end
    end

    // Monitor / checker.
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int beat    = 0;
    int wait_cnt = 0;
    int done    = 0;
    int fin     = 0;
    int acc_q [$];
    logic           rst_prev = 1'b0;
    logic           rsp_prev = 1'b0;
    logic [PAW-1:0] cur_addr = '0;
    logic           cur_we   = 1'b0;
    logic [WW-1:0]  cur_wd   = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk0) begin
        cyc++;
        if (rst_prev) begin
            chk("rst_csb",   32'(sram_csb0),  1);
            chk("rst_web",   32'(sram_web0),  1);
            chk("rst_addr",  32'(sram_addr0), 0);
            chk("rst_din",   32'(sram_din0),  0);
            chk("rst_rsp_v", 32'(rsp_valid),  0);
            chk("rst_rsp_we",32'(rsp_we),     0);
            chk("rst_rdata", 32'(rsp_rdata),  0);
            if (!rst0) chk("ready_after_rst", 32'(req_ready), 1);
        end
        if (rst0) begin
            chk("ready_in_rst", 32'(req_ready), 0);
            exp_q.delete();
            acc_q.delete();
            beat     = 0;
            rsp_prev = 1'b0;
            wait_cnt = 0;
        end else begin
            if (!sram_csb0) begin
                chk("sram_addr", 32'(sram_addr0),
                    32'(int'(cur_addr) * BEATS + beat));
                chk("sram_web", 32'(sram_web0), 32'(!cur_we));
                if (cur_we)
                    chk("sram_din", 32'(sram_din0),
                        32'(cur_wd[beat*DW +: DW]));
                beat++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    if (!rsp_prev) begin
                        chk("latency", 32'(cyc - acc_q.pop_front()), 5);
                        chk("beat_count", 32'(beat), BEATS);
                    end
                    chk("rsp_we",    32'(rsp_we),    32'(exp_q[0].we));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q[0].rd));
                    chk("busy_ready", 32'(req_ready), 0);
                    chk("busy_csb",   32'(sram_csb0), 1);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
            rsp_prev = rsp_valid && !rsp_ready;
            if (req_valid && req_ready) begin
                acc_q.push_back(cyc + 1);
                cur_addr = req_addr;
                cur_we   = req_we;
                cur_wd   = req_wdata;
                beat     = 0;
            end
            if (req_valid && !req_ready) wait_cnt++;
            else                         wait_cnt = 0;
            if (wait_cnt == 40) chk("accept_timeout", 32'(req_ready), 1);
        end
        if (done != 0 && fin == 0) begin
            chk("queue_drained", 32'(exp_q.size()), 0);
            for (int a = 0; a < NPW; a++)
                for (int b = 0; b < BEATS; b++)
                    chk($sformatf("mem_%0d_%0d", a, b),
                        32'(mem[a*BEATS+b]), 32'(ref_mem[a][b*DW +: DW]));
            fin = 1;
        end
        rst_prev = rst0;
    end

    task automatic send(input logic we, input logic [PAW-1:0] a,
                        input logic [WW-1:0] wd, input logic hold);
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk0);
            if (req_ready) break;
        end
        @(posedge clk0);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !rsp_valid) break;
            @(posedge clk0);
            #1;
        end
    endtask

    initial begin
        rst0 = 1'b1;
        repeat (3) @(posedge clk0);
        #1 rst0 = 1'b0;

        send(1'b1, 2'd2, 8'hB4, 1'b0);
        drain();
        send(1'b0, 2'd2, 8'h00, 1'b0);
        drain();

        stall = 1;
        send(1'b0, 2'd2, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk0);
            if (rsp_valid) break;
        end
        repeat (3) @(negedge clk0);
        stall = 0;
        drain();

        send(1'b1, 2'd3, 8'hFF, 1'b0);
        drain();
        send(1'b0, 2'd3, 8'h00, 1'b0);
        drain();

        // Read aborted by reset two edges after accept.
        send(1'b0, 2'd1, 8'h00, 1'b0);
        @(posedge clk0);
        #1 rst0 = 1'b1;
        @(posedge clk0);
        #1 rst0 = 1'b0;
        repeat (10) @(posedge clk0);
        #1;

        for (int a = 0; a < NPW; a++) begin
            send(1'b1, PAW'(a), WW'($urandom), 1'b0);
            drain();
        end

        rmode = 1;
        for (int t = 0; t < 40; t++) begin
            send(1'($urandom_range(0, 1)), PAW'($urandom),
                 WW'($urandom), 1'($urandom_range(0, 1)));
        end
        req_valid = 1'b0;
        drain();
        rmode = 0;

        done = 1;
        for (int i = 0; i < 10; i++) begin
            if (fin != 0) break;
            @(posedge clk0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_sram_seq.md
IMEM_SRAM_SEQ -- requirements
Module: imem_sram_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 2: SRAM word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: SRAM address width.
REQ-003 SHALL have parameter BEATS, default 4, power of two: SRAM words per packed word; BEAT_BITS = log2(BEATS); WORD_WIDTH = DATA_WIDTH*BEATS (8).
REQ-004 SHALL have port clk0  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst0  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when both high at a rising edge.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH-BEAT_BITS  packed-word address.
REQ-010 SHALL have port req_wdata  input  WORD_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when both high at a rising edge.
REQ-013 SHALL have port rsp_we  output  1  echo of accepted req_we.
REQ-014 SHALL have port rsp_rdata  output  WORD_WIDTH  assembled read data; 0 after a write.
REQ-015 SHALL have ports sram_csb0, sram_web0 (output, 1, active-low chip select / write enable), sram_addr0 (output, ADDR_WIDTH), sram_din0 (output, DATA_WIDTH), sram_dout0 (input, DATA_WIDTH), driving one single-port SRAM macro that registers inputs on posedge and updates dout on the following negedge.

Function
REQ-016 All outputs except req_ready SHALL be registered; req_ready = (state==IDLE) && !rst0.
REQ-017 FSM states SHALL be IDLE, ISSUE, DRAIN, RESP.
REQ-018 IDLE: on accept edge E0, SHALL latch req_addr/req_we/req_wdata, set beat=0, drive sram_csb0=0, sram_web0=!req_we, sram_addr0={req_addr,0}, sram_din0=req_wdata[DATA_WIDTH-1:0], go ISSUE.
REQ-019 ISSUE: each edge SHALL increment beat and drive sram_addr0={addr,beat}, sram_din0=wdata slice [beat*DATA_WIDTH +: DATA_WIDTH]; beat 0 = LSBs.
REQ-020 On the edge where beat==BEATS-1 is presented to the SRAM (E4), SHALL drive sram_csb0=1, sram_web0=1, go DRAIN.
REQ-021 For reads, on the edge after each edge at which the SRAM samples a read beat (E2..E5), SHALL capture sram_dout0 into rsp_rdata slice of that beat.
REQ-022 DRAIN: at E5 SHALL set rsp_valid=1, rsp_we=latched we, go RESP; latency accept-to-rsp_valid = 5 cycles for reads and writes.
REQ-023 RESP: rsp_valid, rsp_we, rsp_rdata SHALL hold stable until rsp_valid&&rsp_ready; that edge clears rsp_valid and returns to IDLE.
REQ-024 req_valid outside IDLE SHALL be ignored; next accept earliest one edge after response handshake.
REQ-025 SRAM addresses SHALL stay within {addr,0..BEATS-1}; no wrap into adjacent packed words.
REQ-026 sram_csb0 SHALL be 0 for exactly BEATS consecutive SRAM sampling edges per request, 1 otherwise.
REQ-027 Write response SHALL report rsp_rdata=0.

Reset
REQ-028 rst0 high at an edge SHALL force: state IDLE, sram_csb0=1, sram_web0=1, sram_addr0=0, sram_din0=0, rsp_valid=0, rsp_we=0, rsp_rdata=0, beat=0.
REQ-029 req_ready SHALL be 0 while rst0 high.
REQ-030 Reset mid-request SHALL abort with no response; sram_csb0=1 from the next cycle; partially written SRAM words are not restored.

Verification
REQ-031 Write req_addr=2, req_wdata=0xB4 -> SRAM writes addr 8,9,10,11 with 00,01,11,10; rsp_valid 5 cycles after accept, rsp_we=1, rsp_rdata=0.
REQ-032 Read req_addr=2 after REQ-031 -> sram_web0=1, addr 8..11; rsp_rdata=0xB4, rsp_valid 5 cycles after accept.
REQ-033 Read with rsp_ready=0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, sram_csb0=1; returns IDLE on handshake edge.
REQ-034 Write req_addr=3, wdata=0xFF then read -> addresses 12..15 only, addr 0 untouched, rsp_rdata=0xFF.
REQ-035 rst0 pulsed at E2 of a read -> sram_csb0=1 next cycle, no rsp_valid, req_ready=1 first cycle after rst0 low.
REQ-036 req_valid held high during busy request -> exactly one accept per response handshake; no extra SRAM cycles.
